// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and sizing helper for the sequential binary-to-BCD converter
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_e;

  // ceil(width * log10(2)), with log10(2) approximated as 0.30103
  function automatic int bcd_min_digits(input int width);
    return (width * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - one double-dabble digit correction: add 3 when the digit is 5 or more
module bcd_digit_adj (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  always_comb begin
    dout = din;
    if (din >= 4'd5) begin
      dout = din + 4'd3;
    end
  end

endmodule

// File: rtl/bcd_converter_seq.sv
// rtl/bcd_converter_seq.sv - sequential shift-add-3 binary-to-BCD converter, one input bit per clock
module bcd_converter_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5,
  parameter bit SIGNED = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  negative,
  output logic                  overflow
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

  bcd_state_e        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  shreg_q, shreg_d;
  logic [BW-1:0]     acc_q, acc_d;
  logic              ovf_q, ovf_d;
  logic              sign_q, sign_d;
  logic [BW-1:0]     bcd_q, bcd_d;
  logic              negative_q, negative_d;
  logic              overflow_q, overflow_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              neg_in;
  logic [WIDTH-1:0]  mag;
  logic [BW-1:0]     adj;
  logic [BW-1:0]     acc_shift;
  logic              carry;

  // -2^(WIDTH-1) negates to itself, which read as unsigned is the correct magnitude
  assign neg_in = SIGNED && bin[WIDTH-1];
  assign mag    = neg_in ? (~bin + WIDTH'(1)) : bin;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (acc_q[4*g +: 4]),
      .dout (adj[4*g +: 4])
    );
  end

  assign carry     = adj[BW-1];
  assign acc_shift = {adj[BW-2:0], shreg_q[WIDTH-1]};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    acc_d      = acc_q;
    ovf_d      = ovf_q;
    sign_d     = sign_q;
    bcd_d      = bcd_q;
    negative_d = negative_q;
    overflow_d = overflow_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d = SHIFT;
          busy_d  = 1'b1;
          shreg_d = mag;
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = CNT_LOAD;
          sign_d  = neg_in;
        end
      end
      SHIFT: begin
        acc_d   = acc_shift;
        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        ovf_d   = ovf_q | carry;
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          // results are published only on the edge that enters DONE
          state_d    = DONE;
          done_d     = 1'b1;
          bcd_d      = acc_shift;
          overflow_d = ovf_q | carry;
          negative_d = sign_q;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shreg_q    <= '0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      sign_q     <= 1'b0;
      bcd_q      <= '0;
      negative_q <= 1'b0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
      sign_q     <= sign_d;
      bcd_q      <= bcd_d;
      negative_q <= negative_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign bcd      = bcd_q;
  assign negative = negative_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_bcd_converter_seq.sv
// tb/tb_bcd_converter_seq.sv - directed bench for bcd_converter_seq in three configurations
module tb_bcd_converter_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // a: 16 bit / 5 digits unsigned, b: 8 bit / 3 digits signed, c: 16 bit / 4 digits unsigned
  logic        a_start = 1'b0, b_start = 1'b0, c_start = 1'b0;
  logic [15:0] a_bin = '0, c_bin = '0;
  logic [7:0]  b_bin = '0;
  logic        a_busy, a_done, a_neg, a_ovf;
  logic        b_busy, b_done, b_neg, b_ovf;
  logic        c_busy, c_done, c_neg, c_ovf;
  logic [19:0] a_bcd;
  logic [11:0] b_bcd;
  logic [15:0] c_bcd;

  int n_cmp = 0;
  int n_bad = 0;

  bcd_converter_seq #(.WIDTH(16), .DIGITS(5), .SIGNED(1'b0)) u_a (
    .clock(clk), .reset(rst), .start(a_start), .bin(a_bin),
    .busy(a_busy), .done(a_done), .bcd(a_bcd), .negative(a_neg), .overflow(a_ovf));

  bcd_converter_seq #(.WIDTH(8), .DIGITS(3), .SIGNED(1'b1)) u_b (
    .clock(clk), .reset(rst), .start(b_start), .bin(b_bin),
    .busy(b_busy), .done(b_done), .bcd(b_bcd), .negative(b_neg), .overflow(b_ovf));

  bcd_converter_seq #(.WIDTH(16), .DIGITS(4), .SIGNED(1'b0)) u_c (
    .clock(clk), .reset(rst), .start(c_start), .bin(c_bin),
    .busy(c_busy), .done(c_done), .bcd(c_bcd), .negative(c_neg), .overflow(c_ovf));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic sel_done(input int idx);
    case (idx)
      0:       return a_done;
      1:       return b_done;
      default: return c_done;
    endcase
  endfunction

  function automatic logic sel_busy(input int idx);
    case (idx)
      0:       return a_busy;
      1:       return b_busy;
      default: return c_busy;
    endcase
  endfunction

  // start a conversion on instance idx and wait for done, checking busy and latency
  task automatic convert(input int idx, input logic [15:0] val, input int exp_lat, input string tag);
    int cyc;
    case (idx)
      0:       begin a_bin = val;      a_start = 1'b1; end
      1:       begin b_bin = val[7:0]; b_start = 1'b1; end
      default: begin c_bin = val;      c_start = 1'b1; end
    endcase
    tick();
    a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
    cyc = 1;
    while (!sel_done(idx) && cyc < 40) begin
      chk({tag, "_busy"}, {31'd0, sel_busy(idx)}, 32'd1);
      tick();
      cyc++;
    end
    chk({tag, "_latency"}, cyc, exp_lat);
    chk({tag, "_busy_at_done"}, {31'd0, sel_busy(idx)}, 32'd0);
  endtask

  initial begin
    int cyc;
    rst = 1'b1;
    tick();
    tick();
    chk("rst_a_bcd", {12'd0, a_bcd}, 32'd0);
    chk("rst_a_flags", {28'd0, a_busy, a_done, a_neg, a_ovf}, 32'd0);
    chk("rst_b_flags", {28'd0, b_busy, b_done, b_neg, b_ovf}, 32'd0);
    rst = 1'b0;
    tick();

    convert(0, 16'd65535, 17, "a65535");
    chk("a65535_bcd", {12'd0, a_bcd}, 32'h65535);
    chk("a65535_flags", {30'd0, a_neg, a_ovf}, 32'd0);
    tick();
    chk("a_done_one_cycle", {31'd0, a_done}, 32'd0);

    convert(0, 16'd0, 17, "a0");
    chk("a0_bcd", {12'd0, a_bcd}, 32'h00000);
    chk("a0_flags", {30'd0, a_neg, a_ovf}, 32'd0);
    // back-to-back start issued in the DONE cycle
    convert(0, 16'd40960, 17, "a40960");
    chk("a40960_bcd", {12'd0, a_bcd}, 32'h40960);

    convert(1, 16'h0080, 9, "b80");
    chk("b80_bcd", {20'd0, b_bcd}, 32'h128);
    chk("b80_neg_ovf", {30'd0, b_neg, b_ovf}, 32'd2);
    convert(1, 16'h00FF, 9, "bFF");
    chk("bFF_bcd", {20'd0, b_bcd}, 32'h001);
    chk("bFF_neg_ovf", {30'd0, b_neg, b_ovf}, 32'd2);
    convert(1, 16'h007F, 9, "b7F");
    chk("b7F_bcd", {20'd0, b_bcd}, 32'h127);
    chk("b7F_neg_ovf", {30'd0, b_neg, b_ovf}, 32'd0);

    convert(2, 16'd12345, 17, "c12345");
    chk("c12345_bcd", {16'd0, c_bcd}, 32'h2345);
    chk("c12345_ovf", {31'd0, c_ovf}, 32'd1);
    convert(2, 16'd9999, 17, "c9999");
    chk("c9999_bcd", {16'd0, c_bcd}, 32'h9999);
    chk("c9999_ovf", {31'd0, c_ovf}, 32'd0);

    // second start while busy is ignored, and bin changes during SHIFT do not matter
    tick();
    a_bin = 16'd100;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    cyc = 1;
    while (!a_done && cyc < 40) begin
      if (cyc == 5) begin
        a_bin = 16'd200;
        a_start = 1'b1;
      end else begin
        a_start = 1'b0;
        a_bin = 16'hFFFF;
      end
      chk("ign_bcd_held", {12'd0, a_bcd}, 32'h40960);
      chk("ign_excl", {31'd0, a_busy & a_done}, 32'd0);
      tick();
      cyc++;
    end
    a_start = 1'b0;
    chk("ign_latency", cyc, 32'd17);
    chk("ign_bcd", {12'd0, a_bcd}, 32'h00100);
    tick();
    chk("ign_no_second_done", {31'd0, a_done}, 32'd0);

    // reset in cycle 8 of a conversion aborts it
    a_bin = 16'd500;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int i = 1; i < 8; i++) tick();
    chk("pre_rst_busy", {31'd0, a_busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_bcd", {12'd0, a_bcd}, 32'd0);
    chk("mid_rst_flags", {28'd0, a_busy, a_done, a_neg, a_ovf}, 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk("post_rst_no_done", {30'd0, a_done, a_busy}, 32'd0);
      tick();
    end
    convert(0, 16'd321, 17, "a321");
    chk("a321_bcd", {12'd0, a_bcd}, 32'h00321);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
